// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: fetch PC, per-cycle ROM request, one-entry
// stall buffer, delay-slot-aware branch redirect and the IF/ID register.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_address_i,
   output logic        rom_req_o,
   output logic [31:0] rom_addr_o,
   input  logic        rom_ack_i,
   input  logic [31:0] rom_data_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o
);

   logic [31:0] r_fpc;
   logic        r_fb_valid;
   logic [31:0] r_fb_pc;
   logic [31:0] r_fb_inst;
   logic        r_redir_pend;
   logic [31:0] r_redir_tgt;

   logic        w_acc;
   logic        w_redir;
   logic [31:0] w_fpc_nxt;
   logic        w_fb_valid_nxt;
   logic [31:0] w_fb_pc_nxt;
   logic [31:0] w_fb_inst_nxt;
   logic        w_pend_nxt;
   logic [31:0] w_tgt_nxt;
   logic [31:0] w_id_pc_nxt;
   logic [31:0] w_id_inst_nxt;

   // A full buffer under stall has nowhere to put another word, so stop asking.
   assign rom_req_o  = !rst && (!r_fb_valid || !stall_i);
   assign rom_addr_o = r_fpc;
   assign w_acc      = rom_req_o && rom_ack_i;
   // IF/ID holds a bubble while a redirect is pending, so no branch can be live.
   assign w_redir    = branch_flag_i && !r_redir_pend;

   always_comb begin
      w_fpc_nxt      = r_fpc;
      w_fb_valid_nxt = r_fb_valid;
      w_fb_pc_nxt    = r_fb_pc;
      w_fb_inst_nxt  = r_fb_inst;
      w_pend_nxt     = r_redir_pend;
      w_tgt_nxt      = r_redir_tgt;
      w_id_pc_nxt    = id_pc_o;
      w_id_inst_nxt  = id_inst_o;

      if (w_acc) begin
         if (r_redir_pend) begin
            // The word just fetched is the delay slot; jump right after it.
            w_fpc_nxt  = r_redir_tgt;
            w_pend_nxt = 1'b0;
         end else begin
            w_fpc_nxt = r_fpc + 32'd4;
         end
      end

      if (stall_i) begin
         if (w_acc) begin
            w_fb_valid_nxt = 1'b1;
            w_fb_pc_nxt    = r_fpc;
            w_fb_inst_nxt  = rom_data_i;
         end
      end else if (w_redir) begin
         if (r_fb_valid) begin
            // Buffer holds the delay slot; anything fetched now is past it.
            w_id_pc_nxt    = r_fb_pc;
            w_id_inst_nxt  = r_fb_inst;
            w_fb_valid_nxt = 1'b0;
            w_fpc_nxt      = branch_target_address_i;
         end else if (w_acc) begin
            w_id_pc_nxt    = r_fpc;
            w_id_inst_nxt  = rom_data_i;
            w_fpc_nxt      = branch_target_address_i;
         end else begin
            w_id_pc_nxt    = 32'h0;
            w_id_inst_nxt  = 32'h0;
            w_pend_nxt     = 1'b1;
            w_tgt_nxt      = branch_target_address_i;
         end
      end else begin
         if (r_fb_valid) begin
            w_id_pc_nxt    = r_fb_pc;
            w_id_inst_nxt  = r_fb_inst;
            w_fb_valid_nxt = w_acc;
            if (w_acc) begin
               w_fb_pc_nxt   = r_fpc;
               w_fb_inst_nxt = rom_data_i;
            end
         end else if (w_acc) begin
            w_id_pc_nxt    = r_fpc;
            w_id_inst_nxt  = rom_data_i;
         end else begin
            w_id_pc_nxt    = 32'h0;
            w_id_inst_nxt  = 32'h0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fpc        <= RESET_PC;
         r_fb_valid   <= 1'b0;
         r_fb_pc      <= 32'h0;
         r_fb_inst    <= 32'h0;
         r_redir_pend <= 1'b0;
         r_redir_tgt  <= 32'h0;
         id_pc_o      <= 32'h0;
         id_inst_o    <= 32'h0;
      end else begin
         r_fpc        <= w_fpc_nxt;
         r_fb_valid   <= w_fb_valid_nxt;
         r_fb_pc      <= w_fb_pc_nxt;
         r_fb_inst    <= w_fb_inst_nxt;
         r_redir_pend <= w_pend_nxt;
         r_redir_tgt  <= w_tgt_nxt;
         id_pc_o      <= w_id_pc_nxt;
         id_inst_o    <= w_id_inst_nxt;
      end
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage: owns the fetch PC, drives the instruction ROM request interface, buffers one fetched instruction across decode stalls, and holds the IF/ID pipeline register that feeds the decode stage (`pc_i`/`inst_i`). It consumes the decode stage's `branch_flag_o`/`branch_target_address_o` and implements MIPS branch/jump redirection with one architectural delay slot. The ROM may take any number of cycles to answer, and a missing instruction becomes a NOP bubble (all-zero word).

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_i` in 1: decode-stage stall from ctrl. When 1, the IF/ID register holds.
- `branch_flag_i` in 1: from decode. Redirect request for the instruction currently in IF/ID.
- `branch_target_address_i` in 32: from decode. Redirect target.
- `rom_req_o` out 1: fetch request.
- `rom_addr_o` out 32: fetch address. Always equals the fetch PC register `fpc`.
- `rom_ack_i` in 1: ROM answer. When 1, `rom_data_i` is the word at the current cycle's `rom_addr_o`.
- `rom_data_i` in 32: instruction word.
- `id_pc_o` out 32: IF/ID PC, drives decode `pc_i`.
- `id_inst_o` out 32: IF/ID instruction, drives decode `inst_i`. 32'h0 means bubble.

## Operation
- State:
  - `fpc[31:0]`
  - fetch buffer `fb_valid`, `fb_pc`, `fb_inst`
  - `redir_pend`, `redir_tgt[31:0]`
  - IF/ID registers `id_pc_o`, `id_inst_o`
- The ROM interface is per-cycle. `rom_addr_o` may change while `rom_req_o` is high and no ack has arrived. The block ignores `rom_ack_i` while `rom_req_o` is 0.
- `rom_req_o = !rst && (!fb_valid || !stall_i)`.
- An accepted fetch means `rom_req_o && rom_ack_i`. It yields the pair {`fpc`, `rom_data_i`}. Default update on acceptance: `fpc <= fpc + 4`, wrapping modulo 2^32.
- When `stall_i = 1`:
  - IF/ID holds its value.
  - An accepted fetch goes into the buffer. The buffer is necessarily empty in this case.
  - `branch_flag_i` is ignored, because its operands may be unresolved.
- When `stall_i = 0` and no redirect is accepted, IF/ID loads the oldest available instruction:
  - If the buffer is valid, IF/ID takes `fb` and the buffer is cleared. An accepted fetch in the same cycle refills the buffer.
  - Otherwise, if a fetch is accepted, IF/ID takes it directly.
  - Otherwise IF/ID loads a bubble: pc 0, inst 0.
- When `stall_i = 0` and `branch_flag_i = 1`, a redirect is accepted. The oldest available instruction is the delay slot.
  - **Buffer valid:** IF/ID takes `fb`. Any fetch accepted this cycle is discarded. The buffer is cleared. `fpc <= branch_target_address_i`.
  - **Buffer empty, fetch accepted:** IF/ID takes the fetched word. `fpc <= branch_target_address_i`.
  - **Buffer empty, no fetch:** IF/ID loads a bubble. Set `redir_pend <= 1` and `redir_tgt <= branch_target_address_i`. `fpc` is unchanged and still points at the delay slot.
- While `redir_pend = 1`:
  - The next accepted fetch is the delay slot. It is handled normally (IF/ID or buffer), except that `fpc <= redir_tgt` and `redir_pend <= 0`.
  - `branch_flag_i` cannot be accepted, because IF/ID holds a bubble.
- A not-taken branch (`branch_flag_i = 0`) needs no action. Sequential fetch continues.

## Timing
- Reset values, in the same cycle `rst` is sampled:
  - `fpc = RESET_PC`
  - `fb_valid = 0`, `fb_pc = 0`, `fb_inst = 0`
  - `redir_pend = 0`, `redir_tgt = 0`
  - `id_pc_o = 0`, `id_inst_o = 0`
  - `rom_req_o = 0` combinationally while `rst = 1`.
- Reset during `redir_pend` or with a full buffer discards both. The first fetch after reset is from `RESET_PC`.
- Latency: a fetch accepted in cycle t with `stall_i = 0` and the buffer empty appears on `id_*` in cycle t+1.
- Throughput with a zero-wait ROM and no stalls is one instruction per cycle. The first valid `id_inst_o` appears in the second cycle after reset deasserts.
- Buffered fetch: accepted in cycle t, visible on `id_*` in the cycle after the first cycle with `stall_i = 0`.
- No instruction is lost or duplicated across any stall/ack combination.
- A redirect accepted in cycle t sets `rom_addr_o` to the target in cycle t+1, or in the cycle after the delay-slot fetch when a redirect is pending.

## Test plan
- **Reset and sequential fetch:** ROM always acks with data = address. After reset deasserts, `id_pc_o`/`id_inst_o` read 0x0, 0x4, 0x8, 0xC on consecutive cycles, and `rom_req_o` stays 1.
- **Stall:** `stall_i = 1` for 3 cycles while `id_pc_o = 0x8`. The buffer captures 0xC and `rom_req_o` drops. `id` holds 0x8. After release, `id` shows 0xC then 0x10, with no gap or repeat.
- **Taken branch, zero-wait ROM:** branch at 0x10 targeting 0x40. `id_pc_o` sequence is 0x10, 0x14, 0x40, 0x44. Word 0x18 is never presented to decode.
- **Branch with slow ROM:** ROM acks every 3rd cycle and the delay slot is not yet fetched. `id` shows 0x10, bubble(s), 0x14, then 0x40. `rom_addr_o` shows 0x14 until its ack, then 0x40.
- **Branch while the buffer holds the delay slot:** buffer holds 0x14 and 0x18 is acked in the redirect cycle. `id` gets 0x14, 0x18 is dropped, and the next fetch address is the target.
- **Reset mid-redirect:** assert `rst` while `redir_pend = 1`. After release, fetch restarts at `RESET_PC` and the old target is never fetched.
